psum_row_collector: RTL

Downstream consumer of the PE's partial-sum FIFO. It pops PSUM_WIDTH partial sums, accumulates them element-wise across `num_pass` passes of one output row (one pass per filter row or channel) in an internal row buffer, then drains the finished row through a valid/ready output port. It sits between the PE's Psum buffer read side (`Psum_out` / `ren_Psum_buffer`) and the output-map writeback.

---
 rtl/psum_row_collector_if.sv | 34 +++
 rtl/psum_row_collector.sv | 135 +++++++++++++
 2 files changed

// File: rtl/psum_row_collector_if.sv
// Handshake/bus bundle between the Psum FIFO read side, the row collector and the writeback sink.
// Ports: config load (cfg_ld/row_len/num_pass), FIFO pop side (psum_valid/psum_in/psum_ren),
//        row output (out_data/out_valid/out_last/out_ready), status (busy/done).
interface psum_row_collector_if #(
    parameter int PSUM_WIDTH   = 16,
    parameter int ACC_WIDTH    = 20,
    parameter int ROW_LEN_SIZE = 8,
    parameter int PASS_SIZE    = 5
);
    logic                    cfg_ld;
    logic [ROW_LEN_SIZE-1:0] row_len;
    logic [PASS_SIZE-1:0]    num_pass;
    logic                    psum_valid;
    logic [PSUM_WIDTH-1:0]   psum_in;
    logic                    psum_ren;
    logic [ACC_WIDTH-1:0]    out_data;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;
    logic                    busy;
    logic                    done;

    // Driver side: config source, Psum FIFO and output sink.
    modport master (
        output cfg_ld, row_len, num_pass, psum_valid, psum_in, out_ready,
        input  psum_ren, out_data, out_valid, out_last, busy, done
    );

    // Collector side.
    modport slave (
        input  cfg_ld, row_len, num_pass, psum_valid, psum_in, out_ready,
        output psum_ren, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/psum_row_collector.sv
// Pops partial sums from the Psum FIFO, accumulates them over num_pass passes of one row, drains the row.
// Latency: pop is combinational with psum_valid; last pop to out_valid is 1 cycle; 1 element/cycle each way.
// Backpressure: psum_ren held low while draining; out_ready low freezes out_data/out_last/out_valid and idx.
// Ports: clk, rst (async active-high), bus (slave side of psum_row_collector_if).
module psum_row_collector #(
    parameter int PSUM_WIDTH   = 16,
    parameter int ACC_WIDTH    = 20,
    parameter int ROW_LEN_MAX  = 16,
    parameter int ROW_LEN_SIZE = 8,
    parameter int PASS_SIZE    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    psum_row_collector_if.slave   bus
);

    localparam int IDX_W = (ROW_LEN_MAX > 1) ? $clog2(ROW_LEN_MAX) : 1;
    // len_r must be able to hold ROW_LEN_MAX itself, not just ROW_LEN_MAX-1.
    localparam int LEN_W = $clog2(ROW_LEN_MAX + 1);
    localparam int SUM_W = ACC_WIDTH + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [PASS_SIZE-1:0] pass;
    logic [LEN_W-1:0]     len_r;
    logic [PASS_SIZE-1:0] npass_r;
    logic                 done_r;

    logic [ACC_WIDTH-1:0] acc_mem [ROW_LEN_MAX];

    logic [LEN_W-1:0]     len_in;
    logic [PASS_SIZE-1:0] npass_in;
    logic                 idx_last;
    logic                 pass_last;
    logic                 pop;
    logic                 out_fire;
    logic [SUM_W-1:0]     sum_ext;
    logic [ACC_WIDTH-1:0] acc_next;

    // Config sanitising: 0 means 1, oversize row lengths clamp to the buffer depth.
    always_comb begin
        len_in = LEN_W'(ROW_LEN_MAX);
        if (bus.row_len == '0)
            len_in = LEN_W'(1);
        else if (bus.row_len < ROW_LEN_SIZE'(ROW_LEN_MAX))
            len_in = LEN_W'(bus.row_len);
        npass_in = (bus.num_pass == '0) ? PASS_SIZE'(1) : bus.num_pass;
    end

    // In IDLE len_r is 0 so len_r-1 is all ones; idx_last is never consulted there.
    assign idx_last  = (LEN_W'(idx) == (len_r - LEN_W'(1)));
    assign pass_last = (pass == (npass_r - PASS_SIZE'(1)));

    assign pop      = (state == ACCUM) && bus.psum_valid;
    assign out_fire = (state == DRAIN) && bus.out_ready;

    // One extra bit catches the carry; any carry means the accumulator pins at all ones.
    always_comb begin
        sum_ext  = {1'b0, acc_mem[idx]} + SUM_W'(bus.psum_in);
        acc_next = sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
    end

    assign bus.psum_ren  = pop;
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_last  = (state == DRAIN) && idx_last;
    assign bus.out_data  = (state == DRAIN) ? acc_mem[idx] : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            pass    <= '0;
            len_r   <= '0;
            npass_r <= '0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cfg_ld) begin
                        len_r   <= len_in;
                        npass_r <= npass_in;
                        idx     <= '0;
                        pass    <= '0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (pop) begin
                        if (idx_last) begin
                            idx <= '0;
                            if (pass_last)
                                state <= DRAIN;
                            else
                                pass <= pass + PASS_SIZE'(1);
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (idx_last) begin
                            idx    <= '0;
                            pass   <= '0;
                            done_r <= 1'b1;
                            // Same config streams the next row; only reset leaves this loop.
                            state  <= ACCUM;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row buffer needs no reset: pass 0 overwrites every element before it is read.
    always_ff @(posedge clk) begin
        if (pop) begin
            if (pass == '0)
                acc_mem[idx] <= ACC_WIDTH'(bus.psum_in);
            else
                acc_mem[idx] <= acc_next;
        end
    end

endmodule
